peak_sample_streamer: RTL

- Transmit-side sample source for the peak finder: buffers a block of signed samples, then streams one sample per clock on the peak finder's ready/in_data input.
- Pauses while the peak finder reports a result on send_data, and terminates on stop.
- Replaces file-driven stimulus in system builds. Sits between a host/loader write port and the peak finder input.

---
 rtl/peak_sample_streamer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/peak_sample_streamer.sv
// peak_sample_streamer
//   Transmit-side sample source for the peak finder. A host/loader fills a
//   K-entry buffer of signed N-bit samples. On start, the block is streamed one
//   sample per clock on ready/in_data. Streaming pauses while the peak finder
//   raises send_data and ends early on stop. All outputs are registered.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (clears the buffer)
//   wr_en/addr/data   buffer write port, honoured only in IDLE or DONE
//   start, len        begin streaming len samples (len 0 rejected, len>K clamped)
//   send_data, stop   peak finder hold / terminate requests
//   ready, in_data    sample valid strobe and sample presented to the peak finder
//   busy, done        STREAM/HOLD indicator, block-complete flag
//   sent_cnt          samples presented in the current block
//   len_err           one-cycle pulse when start is rejected for len==0
module peak_sample_streamer #(
    parameter int N  = 16,
    parameter int K  = 42,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          send_data,
    input  logic          stop,
    output logic          ready,
    output logic [N-1:0]  in_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] sent_cnt,
    output logic          len_err
);

    localparam logic [AW-1:0] K_AW  = AW'(K);
    localparam logic [AW-1:0] ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [N-1:0]    in_data_q, in_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW-1:0]   sent_cnt_q, sent_cnt_d;
    logic            len_err_q, len_err_d;
    logic [AW-1:0]   len_q, len_d;
    logic [N-1:0]    mem_q [K];
    logic [N-1:0]    mem_d [K];

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        in_data_d  = in_data_q;
        done_d     = done_q;
        sent_cnt_d = sent_cnt_q;
        len_err_d  = 1'b0;
        len_d      = len_q;
        mem_d      = mem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (wr_en && (wr_addr < K_AW)) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (start) begin
                    if (len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_d      = (len > K_AW) ? K_AW : len;
                        state_d    = S_STREAM;
                        ready_d    = 1'b1;
                        in_data_d  = mem_q[0];
                        sent_cnt_d = ONE;
                        done_d     = 1'b0;
                    end
                end
            end

            S_STREAM: begin
                if (stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (send_data) begin
                    // presented sample is consumed; resume continues at sent_cnt
                    state_d = S_HOLD;
                end else if (sent_cnt_q == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    ready_d    = 1'b1;
                    in_data_d  = mem_q[sent_cnt_q];
                    sent_cnt_d = sent_cnt_q + ONE;
                end
            end

            S_HOLD: begin
                if (stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!send_data) begin
                    if (sent_cnt_q == len_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_STREAM;
                        ready_d    = 1'b1;
                        in_data_d  = mem_q[sent_cnt_q];
                        sent_cnt_d = sent_cnt_q + ONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_STREAM) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            in_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sent_cnt_q <= '0;
            len_err_q  <= 1'b0;
            len_q      <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            in_data_q  <= in_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sent_cnt_q <= sent_cnt_d;
            len_err_q  <= len_err_d;
            len_q      <= len_d;
            mem_q      <= mem_d;
        end
    end

    assign ready    = ready_q;
    assign in_data  = in_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = sent_cnt_q;
    assign len_err  = len_err_q;

endmodule
